// File: rtl/load_store_unit_if.sv
// Signal bundle between the execute stage, load_store_unit and data memory.
// slave = the load/store unit itself; master = the core pipeline plus the data memory around it.
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshakes: req_valid/req_ready, rsp_valid/rsp_ready and bus_req/bus_gnt transfer on a rising
    // edge where both are high, and the sender holds its payload stable while waiting. bus_rvalid is a
    // one-cycle pulse with no back-pressure.
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_re;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [4:0]        req_rd;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_wb;
    logic              rsp_err;

    logic                bus_req;
    logic                bus_gnt;
    logic                bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W/8-1:0] bus_be;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_rvalid;
    logic [DATA_W-1:0]   bus_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_re, req_we, req_funct3, req_rd,
        output req_ready,
        input  rsp_ready,
        output rsp_valid, rsp_data, rsp_rd, rsp_wb, rsp_err,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_re, req_we, req_funct3, req_rd,
        input  req_ready,
        output rsp_ready,
        input  rsp_valid, rsp_data, rsp_rd, rsp_wb, rsp_err,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding data-bus access per instruction, extended load data back.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into error responses.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    load_store_unit_if.slave        lsu,
    output logic [1:0]              dbg_state
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;

    logic            is_mem;
    logic            f3_ok;
    logic            bad_op;
    logic [BE_W-1:0] be_n;
    logic [31:0]     wdata_n;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            misaligned;
`endif

    assign dbg_state = state;

    // Picks the addressed byte/halfword out of the bus word; funct3[2] selects zero-extension.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic        s;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00: begin
                s = b[7] & ~f3[2];
                load_extend = {{24{s}}, b};
            end
            2'b01: begin
                s = h[15] & ~f3[2];
                load_extend = {{16{s}}, h};
            end
            default: load_extend = word;
        endcase
    endfunction

    always_comb begin
        is_mem = lsu.req_re | lsu.req_we;
        if (lsu.req_we) f3_ok = lsu.req_funct3 inside {3'b000, 3'b001, 3'b010};
        else            f3_ok = lsu.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bad_op = (lsu.req_re & lsu.req_we) | ~f3_ok;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((lsu.req_funct3[1:0] == 2'b01) && lsu.req_addr[0]) ||
                     ((lsu.req_funct3[1:0] == 2'b10) && (lsu.req_addr[1:0] != 2'b00));
        bad_op = bad_op | misaligned;
`endif
        // Loads fetch the whole word; stores replicate the datum into every lane it could land in.
        be_n    = 4'b1111;
        wdata_n = '0;
        if (lsu.req_we) begin
            case (lsu.req_funct3[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << lsu.req_addr[1:0];
                    wdata_n = {4{lsu.req_wdata[7:0]}};
                end
                2'b01: begin
                    be_n    = 4'b0011 << {lsu.req_addr[1], 1'b0};
                    wdata_n = {2{lsu.req_wdata[15:0]}};
                end
                default: wdata_n = lsu.req_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            lane_q        <= '0;
            funct3_q      <= '0;
            lsu.req_ready <= 1'b1;
            lsu.rsp_valid <= 1'b0;
            lsu.rsp_data  <= '0;
            lsu.rsp_rd    <= '0;
            lsu.rsp_wb    <= 1'b0;
            lsu.rsp_err   <= 1'b0;
            lsu.bus_req   <= 1'b0;
            lsu.bus_we    <= 1'b0;
            lsu.bus_addr  <= '0;
            lsu.bus_be    <= '0;
            lsu.bus_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu.req_valid) begin
                        lsu.req_ready <= 1'b0;
                        lsu.rsp_rd    <= lsu.req_rd;
                        lsu.rsp_wb    <= 1'b0;
                        lsu.rsp_err   <= 1'b0;
                        lsu.rsp_data  <= '0;
                        lane_q        <= lsu.req_addr[1:0];
                        funct3_q      <= lsu.req_funct3;
                        if (!is_mem) begin
                            lsu.rsp_valid <= 1'b1;
                            state         <= S_RESP;
                        end else if (bad_op) begin
                            lsu.rsp_err   <= 1'b1;
                            lsu.rsp_data  <= DATA_W'(lsu.req_addr);
                            lsu.rsp_valid <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            lsu.bus_req   <= 1'b1;
                            lsu.bus_we    <= lsu.req_we;
                            lsu.bus_addr  <= {lsu.req_addr[ADDR_W-1:2], 2'b00};
                            lsu.bus_be    <= be_n;
                            lsu.bus_wdata <= wdata_n;
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (lsu.bus_gnt) begin
                        lsu.bus_req <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // bus_we still holds the captured access direction here.
                    if (lsu.bus_rvalid) begin
                        lsu.rsp_valid <= 1'b1;
                        if (lsu.bus_we) begin
                            lsu.rsp_data <= '0;
                            lsu.rsp_wb   <= 1'b0;
                        end else begin
                            lsu.rsp_data <= load_extend(lsu.bus_rdata, lane_q, funct3_q);
                            lsu.rsp_wb   <= 1'b1;
                        end
                        state <= S_RESP;
                    end
                end
                default: begin
                    if (lsu.rsp_ready) begin
                        lsu.rsp_valid <= 1'b0;
                        lsu.req_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: reference model feeds a response scoreboard and a
// bus-side memory model that checks every bus request it sees.
module tb_load_store_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         spur_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) lsu_if_i ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .lsu       (lsu_if_i.slave),
        .dbg_state (dbg_state)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wb;
        logic        err;
        logic [7:0]  lat;
        logic [7:0]  hold;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        chk_wd;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  g;
        logic [7:0]  r;
    } bus_t;

    localparam int RSP_W = $bits(rsp_t);
    localparam int BUS_W = $bits(bus_t);

    logic [RSP_W-1:0] exp_q[$];
    logic [BUS_W-1:0] bus_q[$];
    int               acc_q[$];
    int               ld_tab[5] = '{0, 1, 2, 4, 5};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the unit must do with one instruction, from the ISA rules.
    function automatic void model(input logic [31:0] addr, input logic [31:0] wdata, input logic re,
                                  input logic we, input logic [2:0] f3, input logic [4:0] rd,
                                  input logic [31:0] rdata, output rsp_t e, output bus_t b,
                                  output bit uses_bus);
        int          size;
        bit          uns;
        bit          legal;
        int          off;
        int          hoff;
        logic [31:0] v;
        e = '0;
        b = '0;
        uses_bus = 1'b0;
        e.rd = rd;
        e.lat = 8'd1;
        size = int'(f3) % 4;
        uns = (int'(f3) >= 4);
        if (we) legal = (int'(f3) <= 2);
        else    legal = (int'(f3) != 3) && (int'(f3) <= 5);
        off  = addr % 32'd4;
        hoff = (addr / 32'd2) % 32'd2;
        if (!re && !we) begin
            e.data = 32'd0;
        end else if ((re && we) || !legal) begin
            e.err  = 1'b1;
            e.data = addr;
`ifdef LSU_MISALIGN_TRAP_EN
        end else if ((size == 1 && addr % 32'd2 != 0) || (size == 2 && addr % 32'd4 != 0)) begin
            e.err  = 1'b1;
            e.data = addr;
`endif
        end else begin
            uses_bus = 1'b1;
            b.we     = we;
            b.addr   = addr - (addr % 32'd4);
            b.rdata  = rdata;
            if (we) begin
                b.chk_wd = 1'b1;
                if (size == 0) begin
                    b.be    = 4'(1 << off);
                    b.wdata = (wdata % 32'd256) * 32'h01010101;
                end else if (size == 1) begin
                    b.be    = 4'(3 << (2 * hoff));
                    b.wdata = (wdata % 32'd65536) * 32'h00010001;
                end else begin
                    b.be    = 4'hF;
                    b.wdata = wdata;
                end
            end else begin
                b.be = 4'hF;
                if (size == 0) begin
                    v = (rdata >> (8 * off)) % 32'd256;
                    if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
                end else if (size == 1) begin
                    v = (rdata >> (16 * hoff)) % 32'd65536;
                    if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
                end else begin
                    v = rdata;
                end
                e.data = v;
                e.wb   = 1'b1;
            end
        end
    endfunction

    // Presents one instruction, holds it until accepted, and records what must come back.
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic re,
                         input logic we, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rdata, input int g, input int r, input int hold);
        rsp_t e;
        bus_t b;
        bit   ub;
        bit   done;
        model(addr, wdata, re, we, f3, rd, rdata, e, b, ub);
        b.g    = 8'(g);
        b.r    = 8'(r);
        e.hold = 8'(hold);
        if (ub) e.lat = 8'(3 + g + r);
        lsu_if_i.req_addr   = addr;
        lsu_if_i.req_wdata  = wdata;
        lsu_if_i.req_re     = re;
        lsu_if_i.req_we     = we;
        lsu_if_i.req_funct3 = f3;
        lsu_if_i.req_rd     = rd;
        lsu_if_i.req_valid  = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (lsu_if_i.req_ready) begin
                exp_q.push_back(e);
                acc_q.push_back(cyc + 1);
                if (ub) bus_q.push_back(b);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check("req_accept_timeout", 0, 1);
        lsu_if_i.req_valid  = 1'b0;
        lsu_if_i.req_addr   = $urandom;
        lsu_if_i.req_wdata  = $urandom;
        lsu_if_i.req_funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, lsu_if_i.req_ready, 1);
        check({tag, "_rsp_valid"}, lsu_if_i.rsp_valid, 0);
        check({tag, "_rsp_wb"},    lsu_if_i.rsp_wb, 0);
        check({tag, "_rsp_err"},   lsu_if_i.rsp_err, 0);
        check({tag, "_rsp_data"},  lsu_if_i.rsp_data, 0);
        check({tag, "_rsp_rd"},    lsu_if_i.rsp_rd, 0);
        check({tag, "_bus_req"},   lsu_if_i.bus_req, 0);
        check({tag, "_bus_we"},    lsu_if_i.bus_we, 0);
        check({tag, "_bus_addr"},  lsu_if_i.bus_addr, 0);
        check({tag, "_bus_be"},    lsu_if_i.bus_be, 0);
        check({tag, "_bus_wdata"}, lsu_if_i.bus_wdata, 0);
        check({tag, "_state"},     dbg_state, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Response monitor: pops the scoreboard, applies the per-op rsp_ready hold, checks stability.
    initial begin : rsp_monitor
        rsp_t        e;
        int          acc;
        int          waited;
        bit          holding;
        bit          just_done;
        logic [38:0] snap;
        e = '0;
        acc = 0;
        waited = 0;
        holding = 1'b0;
        just_done = 1'b0;
        snap = '0;
        lsu_if_i.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                holding = 1'b0;
                just_done = 1'b0;
                lsu_if_i.rsp_ready = 1'b0;
            end else begin
                if (just_done) check("req_ready_after_rsp", lsu_if_i.req_ready, 1);
                just_done = 1'b0;
                if (lsu_if_i.rsp_valid) begin
                    check("req_ready_while_rsp", lsu_if_i.req_ready, 0);
                    if (!holding) begin
                        if (exp_q.size() == 0) begin
                            check("rsp_unexpected", 1, 0);
                            e = '0;
                        end else begin
                            e = exp_q.pop_front();
                            acc = acc_q.pop_front();
                            check("rsp_latency", cyc - acc + 1, e.lat);
                            check("rsp_data", lsu_if_i.rsp_data, e.data);
                            check("rsp_rd", lsu_if_i.rsp_rd, e.rd);
                            check("rsp_wb", lsu_if_i.rsp_wb, e.wb);
                            check("rsp_err", lsu_if_i.rsp_err, e.err);
                        end
                        holding = 1'b1;
                        waited = 0;
                        snap = {lsu_if_i.rsp_data, lsu_if_i.rsp_rd, lsu_if_i.rsp_wb, lsu_if_i.rsp_err};
                    end else begin
                        check("rsp_stable", {lsu_if_i.rsp_data, lsu_if_i.rsp_rd, lsu_if_i.rsp_wb,
                                             lsu_if_i.rsp_err}, snap);
                    end
                    if (waited >= int'(e.hold)) begin
                        lsu_if_i.rsp_ready = 1'b1;
                        holding = 1'b0;
                        just_done = 1'b1;
                    end else begin
                        lsu_if_i.rsp_ready = 1'b0;
                        waited++;
                    end
                end else begin
                    lsu_if_i.rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Data-memory model: checks each bus request, grants after g cycles, answers r cycles later.
    initial begin : mem_model
        bus_t        b;
        int          mst;
        int          cnt;
        logic [69:0] snap;
        b = '0;
        mst = 0;
        cnt = 0;
        snap = '0;
        lsu_if_i.bus_gnt = 1'b0;
        lsu_if_i.bus_rvalid = 1'b0;
        lsu_if_i.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mst = 0;
                lsu_if_i.bus_gnt = 1'b0;
                lsu_if_i.bus_rvalid = 1'b0;
            end else begin
                case (mst)
                    0: begin
                        lsu_if_i.bus_gnt = 1'b0;
                        lsu_if_i.bus_rvalid = 1'b0;
                        if (lsu_if_i.bus_req) begin
                            if (bus_q.size() == 0) begin
                                check("bus_unexpected", 1, 0);
                                b = '0;
                            end else begin
                                b = bus_q.pop_front();
                                check("bus_we", lsu_if_i.bus_we, b.we);
                                check("bus_addr", lsu_if_i.bus_addr, b.addr);
                                check("bus_be", lsu_if_i.bus_be, b.be);
                                if (b.chk_wd) check("bus_wdata", lsu_if_i.bus_wdata, b.wdata);
                            end
                            snap = {lsu_if_i.bus_req, lsu_if_i.bus_we, lsu_if_i.bus_addr,
                                    lsu_if_i.bus_be, lsu_if_i.bus_wdata};
                            cnt = 0;
                            if (b.g == 0) begin
                                lsu_if_i.bus_gnt = 1'b1;
                                mst = 2;
                            end else begin
                                mst = 1;
                            end
                        end else if (spur_on || $urandom_range(0, 7) == 0) begin
                            lsu_if_i.bus_rvalid = 1'b1;
                            lsu_if_i.bus_gnt = 1'($urandom_range(0, 1));
                            lsu_if_i.bus_rdata = $urandom;
                        end
                    end
                    1: begin
                        check("bus_hold", {lsu_if_i.bus_req, lsu_if_i.bus_we, lsu_if_i.bus_addr,
                                           lsu_if_i.bus_be, lsu_if_i.bus_wdata}, snap);
                        cnt++;
                        if (cnt >= int'(b.g)) begin
                            lsu_if_i.bus_gnt = 1'b1;
                            mst = 2;
                        end
                    end
                    2: begin
                        lsu_if_i.bus_gnt = 1'b0;
                        check("bus_req_drop", lsu_if_i.bus_req, 0);
                        cnt = 0;
                        if (b.r == 0) begin
                            lsu_if_i.bus_rvalid = 1'b1;
                            lsu_if_i.bus_rdata = b.rdata;
                            mst = 3;
                        end else begin
                            mst = 4;
                        end
                    end
                    4: begin
                        cnt++;
                        if (cnt >= int'(b.r)) begin
                            lsu_if_i.bus_rvalid = 1'b1;
                            lsu_if_i.bus_rdata = b.rdata;
                            mst = 3;
                        end
                    end
                    default: begin
                        lsu_if_i.bus_rvalid = 1'b0;
                        lsu_if_i.bus_rdata = $urandom;
                        mst = 0;
                    end
                endcase
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int          sel;
        logic        re;
        logic        we;
        logic [2:0]  f3;
        int          k;
        lsu_if_i.req_valid  = 1'b0;
        lsu_if_i.req_addr   = '0;
        lsu_if_i.req_wdata  = '0;
        lsu_if_i.req_re     = 1'b0;
        lsu_if_i.req_we     = 1'b0;
        lsu_if_i.req_funct3 = '0;
        lsu_if_i.req_rd     = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);

        // Directed: addr, wdata, re, we, funct3, rd, rdata, gnt delay, rvalid delay, rsp_ready hold.
        issue(32'h100, 32'h0, 1, 0, 3'b010, 5'd5,  32'hDEADBEEF, 0, 0, 0);
        issue(32'h103, 32'h0, 1, 0, 3'b000, 5'd6,  32'h80FF7F01, 0, 0, 0);
        issue(32'h103, 32'h0, 1, 0, 3'b100, 5'd7,  32'h80FF7F01, 1, 0, 0);
        issue(32'h102, 32'h0, 1, 0, 3'b101, 5'd8,  32'h80FF7F01, 0, 1, 0);
        issue(32'h10A, 32'h0, 1, 0, 3'b001, 5'd9,  32'h9ABC1234, 0, 0, 1);
        issue(32'h202, 32'h123456AB, 0, 1, 3'b000, 5'd10, 32'h0, 0, 0, 0);
        issue(32'h206, 32'hCAFEF00D, 0, 1, 3'b001, 5'd11, 32'h0, 2, 1, 0);
        issue(32'h204, 32'h87654321, 0, 1, 3'b010, 5'd12, 32'h0, 4, 0, 3);
        issue(32'h101, 32'h0, 1, 0, 3'b010, 5'd13, 32'h11223344, 0, 0, 0);
        issue(32'h303, 32'h0, 1, 0, 3'b001, 5'd14, 32'hA5B6C7D8, 0, 0, 0);
        issue(32'h400, 32'h0, 1, 1, 3'b010, 5'd15, 32'h0, 0, 0, 0);
        issue(32'h404, 32'h0, 1, 0, 3'b011, 5'd16, 32'h0, 0, 0, 2);
        issue(32'h408, 32'h5, 0, 1, 3'b100, 5'd17, 32'h0, 0, 0, 0);
        issue(32'h40C, 32'h0, 0, 0, 3'b010, 5'd18, 32'h0, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 19);
            re = (sel < 10) || (sel == 19);
            we = ((sel >= 10) && (sel < 17)) || (sel == 19);
            if (sel >= 17 && sel < 19) we = 1'b0;
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = 3'(ld_tab[$urandom_range(0, 4)]);
            issue($urandom, $urandom, re, we, f3, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Reset in the middle of a load that is waiting for its data.
        issue(32'h500, 32'h0, 1, 0, 3'b010, 5'd20, 32'h13579BDF, 0, 20, 0);
        k = 0;
        while (dbg_state != 2'd2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("reach_wait_state", dbg_state, 2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midop");
        exp_q.delete();
        acc_q.delete();
        bus_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        spur_on = 1'b1;
        repeat (4) @(negedge clk);
        spur_on = 1'b0;
        check("post_rst_rsp_valid", lsu_if_i.rsp_valid, 0);
        check("post_rst_req_ready", lsu_if_i.req_ready, 1);
        check("post_rst_bus_req", lsu_if_i.bus_req, 0);
        check("post_rst_state", dbg_state, 0);
        @(negedge clk);

        issue(32'h600, 32'h0, 1, 0, 3'b000, 5'd21, 32'h000000F0, 0, 0, 0);
        drain();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute/ALU stage.
- Consumes the ALU-computed address, rs2 store data, mem_read/mem_write and funct3.
- Drives a single-outstanding request/grant/rvalid data-memory bus and returns sign/zero-extended load data for register write-back.
- Multi-cycle: the core holds the instruction while req_ready is low.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and bus_addr.
- DATA_W, 32, data width. Only 32 is supported; bus_be is DATA_W/8 bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  execute stage presents a memory op.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_addr  input  ADDR_W  byte address (ALU result).
- req_wdata  input  32  store data (rs2 value).
- req_re  input  1  load (mem_read).
- req_we  input  1  store (mem_write).
- req_funct3  input  3  access size/sign.
- req_rd  input  5  destination register.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  write-back accepts response.
- rsp_data  output  32  extended load data, or faulting address on error.
- rsp_rd  output  5  captured req_rd.
- rsp_wb  output  1  write rsp_data to rsp_rd.
- rsp_err  output  1  illegal or misaligned access.
- bus_req  output  1  bus request.
- bus_gnt  input  1  bus accepted request.
- bus_we  output  1  bus write.
- bus_addr  output  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_rvalid  input  1  read data / write ack.
- bus_rdata  input  32  read word.

Behaviour:
- Reset (reset=0, async): state IDLE; req_ready=1; rsp_valid, rsp_wb, rsp_err, bus_req, bus_we = 0; rsp_data, rsp_rd, bus_addr, bus_be, bus_wdata = 0. Asserting reset mid-operation abandons the access immediately, with no response.
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered.
- IDLE:
  - A request is accepted when req_valid && req_ready. The unit captures addr, wdata, funct3, rd, re and we.
  - Legal load or store: go to REQ.
  - Illegal op: go to RESP with rsp_err=1, rsp_wb=0, rsp_data=req_addr, and no bus access. Illegal means re && we both set, or a funct3 not listed below.
  - Neither re nor we set: go to RESP with err=0 and wb=0.
- REQ: bus_req held high with stable bus_addr, bus_we, bus_be and bus_wdata until bus_gnt. On the gnt cycle, bus_req deasserts next edge and the FSM enters WAIT.
- WAIT:
  - Waits for bus_rvalid (ack for stores too). The bus guarantees rvalid no earlier than one cycle after gnt.
  - On rvalid, go to RESP.
  - Load: rsp_data is the extracted lane, rsp_wb=1.
  - Store: rsp_data=0, rsp_wb=0.
- RESP: rsp_valid held with stable data until rsp_ready, then return to IDLE. There is no same-cycle re-accept; req_ready rises the following cycle.
- bus_rvalid outside WAIT and bus_gnt outside REQ are ignored.
- Minimum latency: request accepted at edge 0; bus_req at cycle 1; gnt in cycle 1; rvalid in cycle 2; rsp_valid in cycle 3.
- Loads:
  - funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - bus_be=4'b1111 for all loads.
- Stores:
  - funct3 000 SB, 001 SH, 010 SW.
  - SB: bus_be=4'b0001<<addr[1:0], wdata={4{b}}.
  - SH: bus_be=4'b0011<<{addr[1],1'b0}, wdata={2{h}}.
  - SW: bus_be=4'b1111.
- Misaligned access: H with addr[0]=1; W with addr[1:0]!=0. Handling is set by the optional feature.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access goes IDLE->RESP with rsp_err=1, rsp_wb=0 and rsp_data=req_addr. bus_req is never asserted.
- Undefined: misaligned low address bits are ignored. H uses addr[1] only; W ignores addr[1:0]. The access proceeds normally with rsp_err=0.

Test Plan:
- LW addr 0x100; gnt in first REQ cycle; rvalid next cycle with rdata 0xDEADBEEF -> rsp_valid 3 cycles after accept, rsp_data=0xDEADBEEF, rsp_wb=1, rsp_rd=captured rd.
- LB addr 0x103 with rdata 0x80FF7F01 -> rsp_data=0xFFFFFF80. LBU addr 0x103 -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x202, wdata 0x123456AB -> bus_we=1, bus_addr=0x200, bus_be=0100, bus_wdata=0xABABABAB. After rvalid: rsp_valid, rsp_wb=0, rsp_err=0.
- gnt delayed 4 cycles and rsp_ready held low 3 cycles -> bus_req and bus signals stable throughout; rsp held stable; req_ready low until the cycle after rsp_ready.
- LW addr 0x101 -> with LSU_MISALIGN_TRAP_EN: no bus_req, rsp_err=1, rsp_data=0x101. Without the macro: bus_addr=0x100, normal load.
- reset driven low while in WAIT, spurious rvalid after reset released -> all outputs return to reset values asynchronously; rvalid ignored; rsp_valid stays 0; req_ready=1.
